// File: rtl/dist_ram_pkg.sv
// Shared types and helpers for the multi-bank distributed RAM.
package dist_ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } st_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // LSB of field idx in a flattened bus of w-bit fields
    function automatic int unsigned fld_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

    // LSB of bank's slice inside the flattened INIT vector
    function automatic int unsigned init_lo(input int unsigned bank, input int unsigned depth,
                                            input int unsigned w);
        return bank * depth * w;
    endfunction

endpackage

// File: rtl/dist_ram_bank.sv
// One LUT-RAM bank: single synchronous write port, single asynchronous read port.
module dist_ram_bank
    import dist_ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 2,
    parameter int unsigned AW     = clog2(DEPTH),
    parameter logic [DEPTH*DATA_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Power-up contents come from INIT, as for the primitive this models
    logic [DEPTH*DATA_W-1:0] mem = INIT;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[fld_lo(32'(waddr), DATA_W) +: DATA_W] <= wdata;
        end
    end

    assign rdata = mem[fld_lo(32'(raddr), DATA_W) +: DATA_W];

endmodule

// File: rtl/dist_ram_mport.sv
// Multi-bank distributed RAM: shared write address (last port), per-port reads,
// optional output register and reset-triggered sweep-clear.
module dist_ram_mport
    import dist_ram_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned NUM_PORTS  = 4,
    parameter logic [DEPTH*DATA_W*NUM_PORTS-1:0] INIT = '0,
    parameter bit          OUT_REG    = 1'b0,
    parameter bit          WR_FIRST   = 1'b0,
    parameter bit          CLR_ON_RST = 1'b0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                          WCLK,
    input  logic                          RST,
    input  logic                          WE,
    input  logic [NUM_PORTS*AW-1:0]       ADDR,
    input  logic [NUM_PORTS*DATA_W-1:0]   DI,
    input  logic                          DO_CE,
    output logic [NUM_PORTS*DATA_W-1:0]   DO,
    output logic                          BUSY
);

    localparam int unsigned WP = NUM_PORTS - 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    st_t           state    = ST_IDLE;
    logic [AW-1:0] clr_addr = '0;
    logic          busy_q   = 1'b0;

    logic                        clr_we_c;
    logic                        user_we_c;
    logic                        mem_we_c;
    logic [AW-1:0]               waddr_c;
    logic [NUM_PORTS*DATA_W-1:0] wdata_c;
    logic [NUM_PORTS*DATA_W-1:0] rdata_c;

    // Write source select: sweep-clear owns the banks while it runs
    always_comb begin
        clr_we_c  = 1'b0;
        user_we_c = 1'b0;
        clr_we_c  = (state == ST_CLEAR) && !RST;
        user_we_c = WE && !RST && (state == ST_IDLE);
        mem_we_c  = clr_we_c || user_we_c;
        waddr_c   = clr_we_c ? clr_addr : ADDR[fld_lo(WP, AW) +: AW];
        wdata_c   = clr_we_c ? {NUM_PORTS{CLR_VAL}} : DI;
    end

    // Sweep-clear sequencer; reset from any state restarts at address 0
    always_ff @(posedge WCLK) begin
        if (RST) begin
            if (CLR_ON_RST) begin
                state    <= ST_CLEAR;
                clr_addr <= '0;
                busy_q   <= 1'b1;
            end
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + AW'(1);
            if (clr_addr == LAST_ADDR) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end
        end
    end

    assign BUSY = busy_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_bank
        dist_ram_bank #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .AW     (AW),
            .INIT   (INIT[init_lo(p, DEPTH, DATA_W) +: DEPTH*DATA_W])
        ) u_bank (
            .clk   (WCLK),
            .we    (mem_we_c),
            .waddr (waddr_c),
            .wdata (wdata_c[fld_lo(p, DATA_W) +: DATA_W]),
            .raddr (ADDR[fld_lo(p, AW) +: AW]),
            .rdata (rdata_c[fld_lo(p, DATA_W) +: DATA_W])
        );
    end

    if (OUT_REG) begin : g_oreg
        logic [NUM_PORTS*DATA_W-1:0] do_q = '0;

        // Colliding reads optionally see the data being written this edge
        always_ff @(posedge WCLK) begin
            if (RST) begin
                do_q <= '0;
            end else if (DO_CE) begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (WR_FIRST && mem_we_c && (ADDR[fld_lo(p, AW) +: AW] == waddr_c)) begin
                        do_q[fld_lo(p, DATA_W) +: DATA_W] <= wdata_c[fld_lo(p, DATA_W) +: DATA_W];
                    end else begin
                        do_q[fld_lo(p, DATA_W) +: DATA_W] <= rdata_c[fld_lo(p, DATA_W) +: DATA_W];
                    end
                end
            end
        end

        assign DO = do_q;
    end else begin : g_async
        assign DO = rdata_c;
    end

    // DO_CE has no load in the asynchronous-read build
    logic unused_ok;
    assign unused_ok = &{1'b1, DO_CE};

endmodule

// File: tb/tb_dist_ram_mport.sv
// Directed bench for dist_ram_mport: three configurations driven side by side.
module tb_dist_ram_mport;

    localparam logic [255:0] INIT_A  = (256'd2 << 10) | (256'd1 << 80);
    localparam logic [255:0] INIT_BC = (256'd2 << 6) | (256'd1 << 104)
                                     | (256'd3 << 168) | (256'd1 << 254);

    logic WCLK = 1'b0;
    always #5 WCLK = ~WCLK;

    logic        a_rst, a_we, a_doce, a_busy;
    logic [19:0] a_addr;
    logic [7:0]  a_di, a_do;
    logic        b_rst, b_we, b_doce, b_busy;
    logic [19:0] b_addr;
    logic [7:0]  b_di, b_do;
    logic        c_rst, c_we, c_doce, c_busy;
    logic [19:0] c_addr;
    logic [7:0]  c_di, c_do;

    int checks = 0;
    int errors = 0;
    int n;

    dist_ram_mport #(.INIT(INIT_A), .OUT_REG(1'b0), .CLR_ON_RST(1'b0)) u_a (
        .WCLK(WCLK), .RST(a_rst), .WE(a_we), .ADDR(a_addr), .DI(a_di),
        .DO_CE(a_doce), .DO(a_do), .BUSY(a_busy)
    );

    dist_ram_mport #(.INIT(INIT_BC), .OUT_REG(1'b1), .WR_FIRST(1'b0), .CLR_ON_RST(1'b0)) u_b (
        .WCLK(WCLK), .RST(b_rst), .WE(b_we), .ADDR(b_addr), .DI(b_di),
        .DO_CE(b_doce), .DO(b_do), .BUSY(b_busy)
    );

    dist_ram_mport #(.INIT(INIT_BC), .OUT_REG(1'b1), .WR_FIRST(1'b1), .CLR_ON_RST(1'b1),
                     .CLR_VAL(2'b01)) u_c (
        .WCLK(WCLK), .RST(c_rst), .WE(c_we), .ADDR(c_addr), .DI(c_di),
        .DO_CE(c_doce), .DO(c_do), .BUSY(c_busy)
    );

    function automatic logic [19:0] pk(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge WCLK);
        #1;
    endtask

    task automatic rd_all_c(input string tag);
        for (int a = 0; a < 32; a++) begin
            c_addr = pk(5'(a), 5'(a), 5'(a), 5'(a));
            c_doce = 1'b1;
            tick();
            check(tag, c_do, 8'h55);
        end
        c_doce = 1'b0;
    endtask

    // Counts BUSY-high samples from the one just after the last RST edge
    task automatic count_busy(input bit probe, output int cnt);
        cnt = c_busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            if (probe && i == 10) begin
                c_we   = 1'b1;
                c_addr = pk(5'd20, 5'd0, 5'd0, 5'd3);
                c_di   = 8'hFF;
            end
            tick();
            c_we = 1'b0;
            if (probe && i == 21) check("clr_bypass", 8'(c_do[1:0]), 8'h01);
            if (c_busy) cnt++;
            else break;
        end
    endtask

    initial begin
        a_rst = 0; a_we = 0; a_doce = 0; a_addr = pk(5'd5, 5'd0, 5'd0, 5'd0); a_di = '0;
        b_rst = 0; b_we = 0; b_doce = 0; b_addr = '0; b_di = '0;
        c_rst = 0; c_we = 0; c_doce = 0; c_addr = '0; c_di = '0;

        // Power-up, before any clock edge
        #1;
        check("pwr_do0", 8'(a_do[1:0]), 8'h02);
        check("pwr_busy_a", 8'(a_busy), 8'h00);
        check("pwr_busy_c", 8'(c_busy), 8'h00);
        check("pwr_doreg_b", b_do, 8'h00);
        check("pwr_doreg_c", c_do, 8'h00);

        // Asynchronous write/read
        a_we = 1; a_addr = pk(5'd0, 5'd0, 5'd0, 5'd7); a_di = 8'hE4;
        tick();
        check("wr_immediate", 8'(a_do[7:6]), 8'h03);
        a_we = 0; a_addr = pk(5'd7, 5'd7, 5'd7, 5'd7);
        #1;
        check("wr_read7", a_do, 8'hE4);
        a_addr = pk(5'd8, 5'd8, 5'd8, 5'd8);
        #1;
        check("wr_read8", a_do, 8'h04);

        // Registered read collision: read-first (b) vs write-first (c)
        b_we = 1; b_addr = pk(5'd9, 5'd0, 5'd0, 5'd9); b_di = 8'h03; b_doce = 1;
        c_we = 1; c_addr = pk(5'd9, 5'd0, 5'd0, 5'd9); c_di = 8'h03; c_doce = 1;
        tick();
        check("coll_rdfirst", b_do, 8'h00);
        check("coll_wrfirst", c_do, 8'h03);
        b_we = 0; b_doce = 0; c_we = 0; c_doce = 0;
        tick();
        check("hold_rdfirst", b_do, 8'h00);
        check("hold_wrfirst", c_do, 8'h03);
        b_doce = 1;
        tick();
        check("after_coll_b", b_do, 8'h03);
        b_doce = 0;

        // Reset without clear: write dropped, memory kept, DO registers zeroed
        b_rst = 1; b_we = 1; b_addr = pk(5'd0, 5'd0, 5'd0, 5'd3); b_di = 8'h55;
        tick();
        b_rst = 0; b_we = 0;
        check("norst_doreg", b_do, 8'h00);
        check("norst_busy", 8'(b_busy), 8'h00);
        b_addr = pk(5'd3, 5'd3, 5'd3, 5'd3); b_doce = 1;
        tick();
        check("norst_word3", b_do, 8'h02);
        b_addr = pk(5'd9, 5'd20, 5'd20, 5'd31);
        tick();
        check("norst_mixed", b_do, 8'h77);
        check("norst_busy2", 8'(b_busy), 8'h00);
        b_doce = 0;

        // Sweep-clear with a dropped write and a write-first probe
        c_rst = 1; c_we = 1; c_addr = pk(5'd0, 5'd0, 5'd0, 5'd3); c_di = 8'hAA;
        tick();
        c_rst = 0; c_we = 0;
        check("clr_doreg", c_do, 8'h00);
        check("clr_busy_on", 8'(c_busy), 8'h01);
        c_addr = pk(5'd20, 5'd0, 5'd0, 5'd3); c_doce = 1;
        count_busy(1'b1, n);
        check("clr_busy_len", 8'(n), 8'd32);
        c_doce = 0;
        rd_all_c("clr_word");

        // Restart: preload, reset, reassert reset mid-sweep (held two cycles)
        c_we = 1; c_addr = pk(5'd0, 5'd0, 5'd0, 5'd5); c_di = 8'hFF;
        tick();
        c_addr = pk(5'd0, 5'd0, 5'd0, 5'd25);
        tick();
        c_we = 0; c_addr = pk(5'd5, 5'd5, 5'd5, 5'd5); c_doce = 1;
        tick();
        check("preload5", c_do, 8'hFF);
        c_doce = 0;
        c_rst = 1;
        tick();
        c_rst = 0;
        repeat (10) tick();
        check("mid_busy", 8'(c_busy), 8'h01);
        c_rst = 1;
        tick();
        tick();
        check("rst_hold_busy", 8'(c_busy), 8'h01);
        c_rst = 0;
        count_busy(1'b0, n);
        check("restart_busy_len", 8'(n), 8'd32);
        rd_all_c("restart_word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
